pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Per-core pipeline sequencer. Drives the write-enable and flush controls of the IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers and the PC enable. Resolves the following in one priority order:
//  halt, D-cache wait, EX-stage redirect (branch/jump), load-use hazard and I-cache miss.
//  Keeps a saturating stall-cycle counter for performance monitoring.
//  Sits beside the datapath in each core; one instance per core.
// PARAMETERS
//  REG_W       5   register index width
//  LU_BUBBLES  1   bubbles inserted per load-use hazard (1..7)
//  STALL_W     16  stall counter width
// PORTS
//  CLK           in   1        core clock
//  RST           in   1        asynchronous, active-high reset
//  ihit          in   1        instruction fetch completed this cycle
//  dhit          in   1        data access completed this cycle
//  mem_req_MEM   in   1        MEM stage holds a load or store
//  memread_EX    in   1        EX stage holds a load
//  rd_EX         in   REG_W    destination register of EX instruction
//  rs1_ID,rs2_ID in   REG_W    source registers of ID instruction
//  use_rs1_ID    in   1        ID instruction reads rs1
//  use_rs2_ID    in   1        ID instruction reads rs2
//  b_en_EX       in   1        branch resolved taken in EX
//  j_en_EX       in   1        jump in EX
//  halt_WB       in   1        halt instruction retiring in WB
//  pc_write      out  1        PC register load enable
//  imemREN       out  1        instruction fetch request
//  Write_IF_ID   out  1        IF/ID register enable
//  flush_IF_ID   out  1        IF/ID register loads a bubble
//  Write_ID_EX   out  1        ID/EX register enable
//  flush_ID_EX   out  1        ID/EX register loads a bubble
//  Write_EX_MEM  out  1        EX/MEM register enable
//  Write_MEM_WB  out  1        MEM/WB register enable
//  halt          out  1        sticky core-halted flag
//  stall_count   out  STALL_W  cycles with pc_write=0 outside HALTED, saturates at all-ones
// BEHAVIOUR
//  States: RUN, LU_STALL, HALTED. Reset: RUN, bubble counter 0, halt 0, stall_count 0.
//  While RST is high, every output is 0.
//  Hazard and miss terms:
//   lu   = memread_EX & rd_EX!=0 & ((use_rs1_ID & rs1_ID==rd_EX) | (use_rs2_ID & rs2_ID==rd_EX))
//   dwait = mem_req_MEM & ~dhit
//   redir = b_en_EX | j_en_EX
//  Default outputs, applied unless a rule below overrides them:
//   all Write_* = 1, pc_write = 1, imemREN = 1, all flush_* = 0.
//  Priority rules, first match wins, evaluated combinationally each cycle:
//   1 HALTED: all Write_* 0, pc_write 0, imemREN 0, halt 1. HALTED is left only by reset.
//   2 halt_WB: Write_MEM_WB 1, all other writes 0, pc_write 0. Next state HALTED.
//   3 dwait: freeze; all Write_* 0, pc_write 0, flushes 0.
//     State and bubble counter hold. A pending redir stays frozen and is serviced on release.
//   4 redir: pc_write 1 (PC loads the target), flush_IF_ID 1, flush_ID_EX 1.
//     Overrides lu and LU_STALL; next state RUN, bubble counter cleared.
//   5 LU_STALL, or lu in RUN: pc_write 0, Write_IF_ID 0, flush_ID_EX 1; downstream stages advance.
//     In RUN with LU_BUBBLES>1: enter LU_STALL with counter = LU_BUBBLES-1.
//     In LU_STALL: the counter decrements each non-frozen cycle; return to RUN when it
//     reaches 1 and decrements to 0.
//   6 ~ihit: pc_write 0, Write_IF_ID 1, flush_IF_ID 1 (bubble); later stages advance.
//  Outputs are pure functions of state and inputs; no added latency.
//  A redirect takes effect in the same cycle it is seen in EX.
//  stall_count increments on each cycle with pc_write=0 while not in HALTED and RST is low.
// STRUCTURE
//  Shared package cpu_types_pkg: regbits_t, and enum hzd_state_t {RUN, LU_STALL, HALTED}.
//  Sub-module stall_counter (saturating counter, parameter STALL_W) is natural.
//  All other logic lives in one always_ff block (state) and one always_comb block (outputs).
// TESTING
//  T1 lu with rd_EX=5, rs1_ID=5, use_rs1_ID=1, ihit=1 -> one cycle of pc_write=0,
//     Write_IF_ID=0, flush_ID_EX=1; then defaults; stall_count=1.
//  T2 same as T1 with rd_EX=0 -> no stall.
//  T3 lu and b_en_EX in the same cycle -> pc_write=1, flush_IF_ID=1, flush_ID_EX=1.
//  T4 mem_req_MEM=1 with dhit low for 3 cycles, j_en_EX=1 -> all writes 0 for 3 cycles,
//     then the redirect is applied in the dhit cycle.
//  T5 LU_BUBBLES=3, lu then dwait for 2 cycles -> 3 bubble cycles plus 2 freeze cycles;
//     stall_count=5.
//  T6 halt_WB=1 -> Write_MEM_WB=1 only; next cycle halt=1 and imemREN=0;
//     RST pulse mid-HALTED -> RUN, halt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared core types: register index type and the hazard sequencer states.
// Imported by the pipeline control logic.
package cpu_types_pkg;

   localparam int REGBITS_W = 5;
   localparam int BUB_W     = 3;

   typedef logic [REGBITS_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      HALTED   = 2'd2
   } hzd_state_t;

endpackage

// File: rtl/stall_counter.sv
// Saturating event counter used for pipeline stall performance monitoring.
// Holds at all-ones once full.
module stall_counter #(
   parameter int STALL_W = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               inc,
   output logic [STALL_W-1:0] count
);

   logic [STALL_W-1:0] count_q;
   logic [STALL_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {STALL_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-core pipeline sequencer: stage enables/flushes, PC enable, halt and
// stall accounting, resolved in a fixed priority order each cycle.
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int REG_W      = 5,
   parameter int LU_BUBBLES = 1,
   parameter int STALL_W    = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ihit,
   input  logic               dhit,
   input  logic               mem_req_MEM,
   input  logic               memread_EX,
   input  logic [REG_W-1:0]   rd_EX,
   input  logic [REG_W-1:0]   rs1_ID,
   input  logic [REG_W-1:0]   rs2_ID,
   input  logic               use_rs1_ID,
   input  logic               use_rs2_ID,
   input  logic               b_en_EX,
   input  logic               j_en_EX,
   input  logic               halt_WB,
   output logic               pc_write,
   output logic               imemREN,
   output logic               Write_IF_ID,
   output logic               flush_IF_ID,
   output logic               Write_ID_EX,
   output logic               flush_ID_EX,
   output logic               Write_EX_MEM,
   output logic               Write_MEM_WB,
   output logic               halt,
   output logic [STALL_W-1:0] stall_count
);

   localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LU_BUBBLES - 1);

   hzd_state_t       state_q, state_d;
   logic [BUB_W-1:0] bub_q, bub_d;

   logic lu;
   logic dwait;
   logic redir;
   logic stall_inc;

   assign lu = memread_EX && (rd_EX != '0) &&
               ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                (use_rs2_ID && (rs2_ID == rd_EX)));
   assign dwait = mem_req_MEM && !dhit;
   assign redir = b_en_EX || j_en_EX;

   always_comb begin
      state_d      = state_q;
      bub_d        = bub_q;
      pc_write     = 1'b1;
      imemREN      = 1'b1;
      Write_IF_ID  = 1'b1;
      flush_IF_ID  = 1'b0;
      Write_ID_EX  = 1'b1;
      flush_ID_EX  = 1'b0;
      Write_EX_MEM = 1'b1;
      Write_MEM_WB = 1'b1;
      halt         = 1'b0;
      stall_inc    = 1'b0;
      if (RST) begin
         pc_write     = 1'b0;
         imemREN      = 1'b0;
         Write_IF_ID  = 1'b0;
         Write_ID_EX  = 1'b0;
         Write_EX_MEM = 1'b0;
         Write_MEM_WB = 1'b0;
      end else if (state_q == HALTED) begin
         pc_write     = 1'b0;
         imemREN      = 1'b0;
         Write_IF_ID  = 1'b0;
         Write_ID_EX  = 1'b0;
         Write_EX_MEM = 1'b0;
         Write_MEM_WB = 1'b0;
         halt         = 1'b1;
      end else if (halt_WB) begin
         pc_write     = 1'b0;
         Write_IF_ID  = 1'b0;
         Write_ID_EX  = 1'b0;
         Write_EX_MEM = 1'b0;
         state_d      = HALTED;
      end else if (dwait) begin
         // full freeze: state and bubble count hold, redirect waits
         pc_write     = 1'b0;
         Write_IF_ID  = 1'b0;
         Write_ID_EX  = 1'b0;
         Write_EX_MEM = 1'b0;
         Write_MEM_WB = 1'b0;
      end else if (redir) begin
         flush_IF_ID  = 1'b1;
         flush_ID_EX  = 1'b1;
         state_d      = RUN;
         bub_d        = '0;
      end else if ((state_q == LU_STALL) || lu) begin
         pc_write     = 1'b0;
         Write_IF_ID  = 1'b0;
         flush_ID_EX  = 1'b1;
         if (state_q == LU_STALL) begin
            bub_d = bub_q - 1'b1;
            if (bub_q == BUB_W'(1)) begin
               state_d = RUN;
            end
         end else if (LU_BUBBLES > 1) begin
            state_d = LU_STALL;
            bub_d   = BUB_INIT;
         end
      end else if (!ihit) begin
         pc_write     = 1'b0;
         flush_IF_ID  = 1'b1;
      end
      stall_inc = !RST && !pc_write && (state_q != HALTED);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= RUN;
         bub_q   <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
      end
   end

   stall_counter #(
      .STALL_W (STALL_W)
   ) u_stall_counter (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (stall_inc),
      .count (stall_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with one-bubble and
// three-bubble load-use configurations driven from shared inputs.
module tb_pipeline_hazard_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       ihit, dhit, mem_req_MEM, memread_EX;
   logic [4:0] rd_EX, rs1_ID, rs2_ID;
   logic       use_rs1_ID, use_rs2_ID, b_en_EX, j_en_EX, halt_WB;

   logic        a_pc, a_im, a_wif, a_fif, a_wid, a_fid, a_wex, a_wmw, a_h;
   logic        b_pc, b_im, b_wif, b_fif, b_wid, b_fid, b_wex, b_wmw, b_h;
   logic [15:0] a_cnt, b_cnt;
   logic [8:0]  o1, o3;

   int passed = 0;
   int total  = 0;

   // {pc_write,imemREN,W_IF_ID,f_IF_ID,W_ID_EX,f_ID_EX,W_EX_MEM,W_MEM_WB,halt}
   localparam logic [8:0] V_RST  = 9'b000000000;
   localparam logic [8:0] V_DEF  = 9'b111010110;
   localparam logic [8:0] V_LU   = 9'b010011110;
   localparam logic [8:0] V_RED  = 9'b111111110;
   localparam logic [8:0] V_FRZ  = 9'b010000000;
   localparam logic [8:0] V_HWB  = 9'b010000010;
   localparam logic [8:0] V_HLT  = 9'b000000001;
   localparam logic [8:0] V_MISS = 9'b011110110;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.REG_W(5), .LU_BUBBLES(1), .STALL_W(16)) dut1 (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .mem_req_MEM(mem_req_MEM), .memread_EX(memread_EX),
      .rd_EX(rd_EX), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
      .b_en_EX(b_en_EX), .j_en_EX(j_en_EX), .halt_WB(halt_WB),
      .pc_write(a_pc), .imemREN(a_im), .Write_IF_ID(a_wif),
      .flush_IF_ID(a_fif), .Write_ID_EX(a_wid), .flush_ID_EX(a_fid),
      .Write_EX_MEM(a_wex), .Write_MEM_WB(a_wmw), .halt(a_h),
      .stall_count(a_cnt)
   );

   pipeline_hazard_ctrl #(.REG_W(5), .LU_BUBBLES(3), .STALL_W(16)) dut3 (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .mem_req_MEM(mem_req_MEM), .memread_EX(memread_EX),
      .rd_EX(rd_EX), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
      .b_en_EX(b_en_EX), .j_en_EX(j_en_EX), .halt_WB(halt_WB),
      .pc_write(b_pc), .imemREN(b_im), .Write_IF_ID(b_wif),
      .flush_IF_ID(b_fif), .Write_ID_EX(b_wid), .flush_ID_EX(b_fid),
      .Write_EX_MEM(b_wex), .Write_MEM_WB(b_wmw), .halt(b_h),
      .stall_count(b_cnt)
   );

   assign o1 = {a_pc, a_im, a_wif, a_fif, a_wid, a_fid, a_wex, a_wmw, a_h};
   assign o3 = {b_pc, b_im, b_wif, b_fif, b_wid, b_fid, b_wex, b_wmw, b_h};

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; mem_req_MEM = 1'b0; memread_EX = 1'b0;
      rd_EX = '0; rs1_ID = '0; rs2_ID = '0;
      use_rs1_ID = 1'b0; use_rs2_ID = 1'b0;
      b_en_EX = 1'b0; j_en_EX = 1'b0; halt_WB = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      idle();
      RST = 1'b1;
      #2;
      RST = 1'b0;
      tick();
   endtask

   task automatic set_lu(input logic [4:0] r);
      memread_EX = 1'b1; rd_EX = r; rs1_ID = r; use_rs1_ID = 1'b1;
   endtask

   initial begin
      idle();
      RST = 1'b1;
      #1;
      check("reset_outs_1", 16'(o1), 16'(V_RST));
      check("reset_outs_3", 16'(o3), 16'(V_RST));
      tick();
      check("reset_cnt", a_cnt, 16'd0);
      RST = 1'b0;
      #1;
      check("idle_defaults", 16'(o1), 16'(V_DEF));

      ihit = 1'b0;
      #1;
      check("imiss_bubble", 16'(o1), 16'(V_MISS));
      tick();
      idle();
      #1;
      check("imiss_cnt", a_cnt, 16'd1);

      // T1
      do_reset();
      set_lu(5'd5);
      #1;
      check("t1_lu", 16'(o1), 16'(V_LU));
      tick();
      idle();
      #1;
      check("t1_after", 16'(o1), 16'(V_DEF));
      check("t1_cnt", a_cnt, 16'd1);

      // T2
      do_reset();
      set_lu(5'd0);
      #1;
      check("t2_rd0", 16'(o1), 16'(V_DEF));
      tick();
      check("t2_cnt", a_cnt, 16'd0);

      // lu via rs2 only
      do_reset();
      memread_EX = 1'b1; rd_EX = 5'd9; rs2_ID = 5'd9; use_rs2_ID = 1'b1;
      rs1_ID = 5'd9;
      #1;
      check("lu_rs2", 16'(o1), 16'(V_LU));
      use_rs2_ID = 1'b0;
      #1;
      check("lu_nouse", 16'(o1), 16'(V_DEF));

      // T3
      do_reset();
      set_lu(5'd7);
      b_en_EX = 1'b1;
      #1;
      check("t3_redir", 16'(o1), 16'(V_RED));
      check("t3_redir3", 16'(o3), 16'(V_RED));
      tick();
      idle();
      #1;
      check("t3_after", 16'(o3), 16'(V_DEF));
      check("t3_cnt", a_cnt, 16'd0);

      // T4
      do_reset();
      mem_req_MEM = 1'b1; j_en_EX = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("t4_freeze%0d", i), 16'(o1), 16'(V_FRZ));
         tick();
      end
      dhit = 1'b1;
      #1;
      check("t4_release", 16'(o1), 16'(V_RED));
      tick();
      idle();
      #1;
      check("t4_after", 16'(o1), 16'(V_DEF));
      check("t4_cnt", a_cnt, 16'd3);

      // T5
      do_reset();
      set_lu(5'd3);
      #1;
      check("t5_b1", 16'(o3), 16'(V_LU));
      tick();
      idle();
      mem_req_MEM = 1'b1;
      #1;
      check("t5_frz0", 16'(o3), 16'(V_FRZ));
      tick();
      #1;
      check("t5_frz1", 16'(o3), 16'(V_FRZ));
      tick();
      mem_req_MEM = 1'b0;
      #1;
      check("t5_b2", 16'(o3), 16'(V_LU));
      tick();
      #1;
      check("t5_b3", 16'(o3), 16'(V_LU));
      tick();
      #1;
      check("t5_after", 16'(o3), 16'(V_DEF));
      check("t5_cnt", b_cnt, 16'd5);

      // T6
      do_reset();
      halt_WB = 1'b1;
      #1;
      check("t6_hwb", 16'(o1), 16'(V_HWB));
      tick();
      halt_WB = 1'b0;
      #1;
      check("t6_halted", 16'(o1), 16'(V_HLT));
      check("t6_cnt", a_cnt, 16'd1);
      tick();
      tick();
      check("t6_held", 16'(o1), 16'(V_HLT));
      check("t6_cnt_hold", a_cnt, 16'd1);
      RST = 1'b1;
      #1;
      check("t6_rst", 16'(o1), 16'(V_RST));
      RST = 1'b0;
      #1;
      check("t6_run", 16'(o1), 16'(V_DEF));
      check("t6_cnt_clr", a_cnt, 16'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
